// File: rtl/m_dm_arb.sv
// Data-memory sequencer: arbitrates the M-stage CPU port and a word-only DMA port
// round-robin onto a single req/ready memory, with store lane steering and alignment checks.
module m_dm_arb #(
  parameter int unsigned AW = 30
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [1:0]    i_cpu_type,
  input  logic [31:0]   i_cpu_addr,
  input  logic [31:0]   i_cpu_wdata,
  output logic [31:0]   o_cpu_rdata,
  output logic          o_cpu_stall,
  output logic          o_cpu_exc,
  input  logic          i_dma_req,
  input  logic          i_dma_we,
  input  logic [31:0]   i_dma_addr,
  input  logic [31:0]   i_dma_wdata,
  output logic [31:0]   o_dma_rdata,
  output logic          o_dma_done,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_be,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata,
  input  logic          i_mem_ready
);

  localparam logic [1:0] TYPE_W = 2'b00;
  localparam logic [1:0] TYPE_H = 2'b01;
  localparam logic [1:0] TYPE_B = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StCpuAcc,
    StCpuDone,
    StDmaAcc,
    StDmaDone
  } state_e;

  state_e          r_state, w_state_nxt;
  logic            r_last_grant;  // 0 = CPU won last, 1 = DMA won last
  logic            r_we;
  logic [3:0]      r_be;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;

  logic            w_misaligned;
  logic            w_cpu_valid;
  logic            w_grant_cpu;
  logic            w_grant_dma;
  logic            w_acc;
  logic [3:0]      w_cpu_be;
  logic [31:0]     w_cpu_wdata;
  logic            w_unused_dma_lsb;

  assign w_unused_dma_lsb = ^i_dma_addr[1:0];

  always_comb begin
    w_misaligned = 1'b1;
    case (i_cpu_type)
      TYPE_W:  w_misaligned = (i_cpu_addr[1:0] != 2'b00);
      TYPE_H:  w_misaligned = i_cpu_addr[0];
      TYPE_B:  w_misaligned = 1'b0;
      default: w_misaligned = 1'b1;
    endcase
  end

  assign o_cpu_exc   = i_cpu_req & w_misaligned;
  assign w_cpu_valid = i_cpu_req & ~w_misaligned;

  // On a tie the requester that did not win last time takes the slot.
  assign w_grant_cpu = (r_state == StIdle) & w_cpu_valid & (~i_dma_req | r_last_grant);
  assign w_grant_dma = (r_state == StIdle) & i_dma_req & (~w_cpu_valid | ~r_last_grant);

  always_comb begin
    w_cpu_be    = 4'b1111;
    w_cpu_wdata = i_cpu_wdata;
    if (i_cpu_we) begin
      case (i_cpu_type)
        TYPE_H: begin
          w_cpu_be    = i_cpu_addr[1] ? 4'b1100 : 4'b0011;
          w_cpu_wdata = {2{i_cpu_wdata[15:0]}};
        end
        TYPE_B: begin
          w_cpu_be    = 4'b0001 << i_cpu_addr[1:0];
          w_cpu_wdata = {4{i_cpu_wdata[7:0]}};
        end
        default: begin
          w_cpu_be    = 4'b1111;
          w_cpu_wdata = i_cpu_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant_cpu)      w_state_nxt = StCpuAcc;
        else if (w_grant_dma) w_state_nxt = StDmaAcc;
      end
      StCpuAcc:  if (i_mem_ready) w_state_nxt = StCpuDone;
      StCpuDone: w_state_nxt = StIdle;
      StDmaAcc:  if (i_mem_ready) w_state_nxt = StDmaDone;
      StDmaDone: w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  assign w_acc = (r_state == StCpuAcc) | (r_state == StDmaAcc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_be         <= 4'b0000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_cpu) begin
        r_we         <= i_cpu_we;
        r_be         <= w_cpu_be;
        r_addr       <= i_cpu_addr[AW+1:2];
        r_wdata      <= w_cpu_wdata;
        r_last_grant <= 1'b0;
      end else if (w_grant_dma) begin
        r_we         <= i_dma_we;
        r_be         <= 4'b1111;
        r_addr       <= i_dma_addr[AW+1:2];
        r_wdata      <= i_dma_wdata;
        r_last_grant <= 1'b1;
      end
      if (w_acc && i_mem_ready) r_rdata <= i_mem_rdata;
    end
  end

  assign o_mem_req   = w_acc;
  assign o_mem_we    = w_acc & r_we;
  assign o_mem_be    = r_be;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_cpu_rdata = r_rdata;
  assign o_dma_rdata = r_rdata;
  assign o_dma_done  = (r_state == StDmaDone);
  // Reset gates the stall so a frozen pipeline is never held by a dead sequencer.
  assign o_cpu_stall = i_rst_n & w_cpu_valid & (r_state != StCpuDone);

endmodule

// File: tb/tb_m_dm_arb.sv
// Scoreboard bench for m_dm_arb: directed test-plan cases then randomized CPU/DMA traffic
// checked against a byte-level shadow memory and per-port expectation queues.
module tb_m_dm_arb;
  localparam int unsigned AW = 30;
  localparam logic [1:0] TW = 2'b00, TH = 2'b01, TB = 2'b10, TX = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cpu_req = 0, cpu_we = 0; logic [1:0] cpu_type = TW;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic cpu_stall, cpu_exc;
  logic dma_req = 0, dma_we = 0; logic [31:0] dma_addr = 0, dma_wdata = 0, dma_rdata;
  logic dma_done;
  logic mem_req, mem_we; logic [3:0] mem_be; logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata; logic mem_ready = 1'b1;

  m_dm_arb #(.AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_type(cpu_type), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .o_cpu_exc(cpu_exc),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(dma_rdata), .o_dma_done(dma_done),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        cpu_mq[$], dma_mq[$], mon_e;
  logic [31:0] cpu_rq[$], dma_rq[$], mon_w;
  int          grant_log[$];
  int          n_checks = 0, n_errors = 0, n_done = 0, n_dma = 0;
  int          first_req, unstable, st;
  logic [3:0]  first_be;
  logic [31:0] first_wd;
  logic [AW-1:0] first_addr;
  bit          rand_ready = 0;
  logic [31:0] mem_arr[256];
  logic [7:0]  shadow[1024];

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] sh_word(int ba);
    return {shadow[ba+3], shadow[ba+2], shadow[ba+1], shadow[ba]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no completion within bound, got none expected one", name);
  endtask

  // Memory: combinational read, write on the accepting edge.
  assign mem_rdata = mem_arr[mem_addr[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (rst_n && mem_req && mem_ready && mem_we)
        for (int l = 0; l < 4; l++)
          if (mem_be[l]) mem_arr[mem_addr[7:0]][8*l +: 8] = mem_wdata[8*l +: 8];
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: CPU owns words 0..63, DMA owns words 64..255.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_ready) begin
        grant_log.push_back(mem_addr < 64 ? 0 : 1);
        if ((mem_addr < 64 && cpu_mq.size() == 0) || (mem_addr >= 64 && dma_mq.size() == 0)) begin
          n_checks++; n_errors++;
          $display("FAIL mem_unexpected: got access at word %h expected none", mem_addr);
        end else begin
          if (mem_addr < 64) mon_e = cpu_mq.pop_front();
          else mon_e = dma_mq.pop_front();
          check("mem_we", mem_we, mon_e.we);
          check("mem_be", mem_be, mon_e.be);
          check("mem_addr", mem_addr, mon_e.addr);
          if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.wdata);
        end
      end
      if (cpu_req && !cpu_exc && !cpu_stall && !cpu_we) begin
        if (cpu_rq.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL cpu_rdata_unexpected: got %h expected no completion", cpu_rdata);
        end else begin
          mon_w = cpu_rq.pop_front();
          check("cpu_rdata", cpu_rdata, mon_w);
        end
      end
      if (dma_done) begin
        n_done++;
        if (!dma_we) begin
          if (dma_rq.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL dma_rdata_unexpected: got %h expected no completion", dma_rdata);
          end else begin
            mon_w = dma_rq.pop_front();
            check("dma_rdata", dma_rdata, mon_w);
          end
        end
      end
    end
  end

  // Starts and ends at posedge+1.
  task automatic cpu_op(input logic we, input logic [1:0] ty, input logic [31:0] addr,
                        input logic [31:0] wd, output int stalls);
    int size, ba, wa;
    bit exc, done;
    logic [3:0] ebe;
    logic [31:0] ewd;
    txn_t e;
    size = (ty == TW) ? 4 : (ty == TH) ? 2 : (ty == TB) ? 1 : 0;
    if (size == 0) exc = 1;
    else exc = (addr % size) != 0;
    cpu_req = 1; cpu_we = we; cpu_type = ty; cpu_addr = addr; cpu_wdata = wd;
    stalls = 0; first_req = -1; unstable = 0;
    if (exc) begin
      @(negedge clk);
      check("exc_flag", cpu_exc, 1);
      check("exc_stall", cpu_stall, 0);
      if (!dma_req) check("exc_mem_req", mem_req, 0);
    end else begin
      ba = int'(addr[9:0]);
      wa = ba & ~3;
      ebe = 4'hF; ewd = 0;
      if (we) begin
        ebe = 0;
        for (int i = 0; i < size; i++) begin
          ebe[ba % 4 + i] = 1'b1;
          shadow[ba + i] = wd[8*i +: 8];
        end
        for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wd[8*(l % size) +: 8];
      end else begin
        cpu_rq.push_back(sh_word(wa));
      end
      e.we = we; e.be = ebe; e.addr = 30'(addr >> 2); e.wdata = ewd;
      cpu_mq.push_back(e);
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (mem_req && mem_addr < 64) begin
          if (first_req < 0) begin
            first_req = c; first_be = mem_be; first_wd = mem_wdata; first_addr = mem_addr;
          end else if (mem_be !== first_be || mem_wdata !== first_wd || mem_addr !== first_addr)
            unstable++;
        end
        if (cpu_stall) stalls++;
        else done = 1;
      end
      if (!done) timeout("cpu_timeout");
      else check("cpu_done_exc", cpu_exc, 0);
    end
    @(posedge clk); #1;
    cpu_req = 0;
  endtask

  task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    int wa;
    bit done;
    txn_t e;
    dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    wa = int'(addr[9:0]) & ~3;
    if (we) for (int i = 0; i < 4; i++) shadow[wa + i] = wd[8*i +: 8];
    else dma_rq.push_back(sh_word(wa));
    e.we = we; e.be = 4'hF; e.addr = 30'(addr >> 2); e.wdata = wd;
    dma_mq.push_back(e);
    n_dma++;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (dma_done) done = 1;
    end
    if (!done) timeout("dma_timeout");
    @(posedge clk); #1;
    dma_req = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_be"}, mem_be, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_dma_done"}, dma_done, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_dma_rdata"}, dma_rdata, 0);
    check({tag, "_cpu_stall"}, cpu_stall, 0);
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) shadow[4*i + b] = w[8*b +: 8];
    end
    // Reset with a valid CPU request present: stall must stay low.
    cpu_req = 1; cpu_type = TW; cpu_addr = 32'h10;
    @(negedge clk);
    reset_checks("rst");
    cpu_req = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    cpu_op(0, TW, 32'h10, 0, st);
    check("lw_stall_cycles", st, 2);
    check("lw_req_cycle", first_req, 1);
    check("lw_addr", first_addr, 4);
    check("lw_be", first_be, 4'hF);

    cpu_op(1, TB, 32'h7, 32'h000000A5, st);
    check("sb_be", first_be, 4'b1000);
    check("sb_wdata", first_wd, 32'hA5A5A5A5);
    cpu_op(1, TH, 32'h6, 32'h00001234, st);
    check("sh_be", first_be, 4'b1100);
    check("sh_wdata", first_wd, 32'h12341234);

    cpu_op(0, TW, 32'h2, 0, st);
    cpu_op(0, TH, 32'h5, 0, st);
    cpu_op(0, TX, 32'h0, 0, st);

    mem_ready = 0;
    fork
      cpu_op(0, TW, 32'h20, 0, st);
      begin repeat (6) @(posedge clk); #1; mem_ready = 1; end
    join
    check("wait_stall_cycles", st, 7);
    check("wait_mem_stable", unstable, 0);

    // Contention straight out of reset.
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    grant_log.delete();
    fork
      begin cpu_op(0, TW, 32'h30, 0, st); cpu_op(1, TW, 32'h34, 32'hCAFEF00D, st); end
      begin dma_op(1, 32'h104, 32'h11223344); dma_op(0, 32'h107, 0); end
    join
    check("arb_grants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("arb_order", grant_log[i], i % 2);

    // Reset while a DMA read is waiting in its access state.
    mem_ready = 0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    begin : find_acc
      bit seen;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        seen = mem_req;
      end
      if (!seen) timeout("midop_acc");
    end
    #1;
    rst_n = 0;
    cpu_req = 1; cpu_we = 0; cpu_type = TW; cpu_addr = 32'h10;
    #1;
    reset_checks("midop");
    @(posedge clk); #1;
    mem_ready = 1;
    rst_n = 1;
    grant_log.delete();
    fork
      cpu_op(0, TW, 32'h10, 0, st);
      dma_op(0, 32'h200, 0);
    join
    check("post_rst_stall", st, 2);
    check("post_rst_req_cycle", first_req, 1);
    check("post_rst_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) check("post_rst_cpu_first", grant_log[0], 0);

    rand_ready = 1;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          logic [1:0] ty; logic [31:0] a; int sz;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          ty = ($urandom_range(0, 9) == 0) ? TX : 2'($urandom_range(0, 2));
          sz = (ty == TW) ? 4 : (ty == TH) ? 2 : 1;
          a = 32'($urandom_range(0, 255));
          if ($urandom_range(0, 99) < 85) a = a & ~(32'(sz) - 1);
          cpu_op(1'($urandom_range(0, 1)), ty, a, $urandom, st);
        end
      end
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          dma_op(1'($urandom_range(0, 1)), 32'($urandom_range(256, 1023)), $urandom);
        end
      end
    join
    rand_ready = 0;
    mem_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    check("cpu_mq_left", cpu_mq.size(), 0);
    check("dma_mq_left", dma_mq.size(), 0);
    check("cpu_rq_left", cpu_rq.size(), 0);
    check("dma_rq_left", dma_rq.size(), 0);
    check("dma_done_count", n_done, n_dma);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m_dm_arb.md
# m_dm_arb

Data-memory access sequencer and arbiter sitting between the M-stage memory port, a secondary word-only DMA port, and a single-port, variable-latency data memory with a req/ready handshake. It performs these functions:
- Checks CPU access alignment.
- Generates store byte enables and lane-replicated write data.
- Arbitrates the memory round-robin.
- Stalls the pipeline until the CPU's access completes.

Raw load words are returned unextended; sign extension is done downstream in M stage.

## Interface
- AW, 30: word-address width driven to memory (mem_addr = addr[AW+1:2]).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- cpu_req  in  1  M-stage load/store valid; held until cpu_stall falls.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_type  in  2  access size: shared-header type_w / type_h / type_b codes; the fourth code is illegal.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_rdata  out  32  raw memory word; valid while state = CPU_DONE.
- cpu_stall  out  1  freeze pipeline.
- cpu_exc  out  1  misaligned or illegal-type access, combinational.
- dma_req  in  1  DMA word access request; held until dma_done.
- dma_we  in  1  1 = write.
- dma_addr  in  32  byte address; bits [1:0] ignored.
- dma_wdata  in  32  write word.
- dma_rdata  out  32  read word; valid while dma_done = 1.
- dma_done  out  1  one-cycle completion pulse.
- mem_req, mem_we  out  1  memory request / write.
- mem_be  out  4  byte enables.
- mem_addr  out  AW  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid when mem_ready = 1.
- mem_ready  in  1  completes the current request in that cycle.

## Operation
- States: IDLE, CPU_ACC, CPU_DONE, DMA_ACC, DMA_DONE. A last_grant bit records the last winner (0 = CPU, 1 = DMA).
- CPU misalignment check (combinational):
  - type_w requires addr[1:0] = 0.
  - type_h requires addr[0] = 0.
  - type_b is always aligned.
  - The illegal type code is always an exception.
- cpu_exc = cpu_req & misaligned. A faulting request is never granted and never stalls.
- IDLE arbitration:
  - Valid requesters are the CPU (cpu_req & ~cpu_exc) and the DMA (dma_req).
  - If only one requester is valid, it wins.
  - If both are valid, the one with last_grant ≠ its ID wins.
  - On a grant, latch we, be, word address and wdata, update last_grant, and enter CPU_ACC or DMA_ACC.
- Store byte enables:
  - w → 1111.
  - h → 0011 (addr[1] = 0) or 1100 (addr[1] = 1).
  - b → 0001 << addr[1:0].
- Store write data is lane-replicated:
  - h → {2{wdata[15:0]}}.
  - b → {4{wdata[7:0]}}.
  - w → unchanged.
- Loads and all DMA accesses use be = 1111.
- ACC states:
  - mem_req = 1, with mem_* driven from the latched registers and held stable.
  - On mem_ready, capture mem_rdata into the read register and go to the matching DONE state.
  - With mem_ready = 0, stay in ACC indefinitely.
- DONE states last one cycle, then return to IDLE.
  - CPU_DONE: cpu_stall = 0.
  - DMA_DONE: dma_done = 1.
- cpu_stall = cpu_req & ~cpu_exc & (state ≠ CPU_DONE).
- If cpu_req drops mid-access (pipeline flush), the access still completes and its result is discarded. A store already in ACC is not cancelled.

## Timing
- Reset (async, reset = 0): state = IDLE, last_grant = 1 (CPU wins the first tie), and the read/latch registers are cleared. Output values while in reset:
  - mem_req = 0, mem_we = 0, mem_be = 0000, mem_addr = 0, mem_wdata = 0.
  - dma_done = 0, cpu_rdata = 0, dma_rdata = 0.
  - cpu_stall = 0 while reset is asserted.
- Reset mid-access: mem_req drops in the same cycle and the transaction is abandoned.
- Minimum CPU latency with mem_ready tied high:
  - cycle 0: IDLE, grant, stall = 1.
  - cycle 1: CPU_ACC, mem_req = 1, stall = 1.
  - cycle 2: CPU_DONE, stall = 0.
  - This is 2 stall cycles; each extra wait cycle of mem_ready adds one.
- DMA minimum: dma_done occurs 2 cycles after the grant cycle.
- A request that loses arbitration waits at least 3 cycles (ACC + DONE of the winner, then IDLE).
- Back-to-back: after CPU_DONE with dma_req pending, the DMA wins the next IDLE even if a new cpu_req is present.
- mem_* outputs are registered or state-decoded. No combinational path from cpu_*/dma_* to mem_*.

## Test plan
- Aligned loads, mem_ready = 1: cpu_req, type_w, addr 0x10, mem_rdata 0xDEADBEEF → mem_req in cycle 1, mem_addr = 0x4, mem_be = 1111; cpu_stall high for 2 cycles; cpu_rdata = 0xDEADBEEF in CPU_DONE.
- Store lanes: sb 0x000000A5 @0x7 → mem_be = 1000, mem_wdata = 0xA5A5A5A5. sh 0x1234 @0x6 → mem_be = 1100, mem_wdata = 0x12341234.
- Misalign: lw @0x2, lh @0x5, and the illegal type → cpu_exc = 1, cpu_stall = 0, mem_req never asserted.
- Contention: cpu_req and dma_req both asserted from reset, repeated → grant order CPU, DMA, CPU, DMA; dma_done pulses exactly once per DMA access.
- Wait states: mem_ready low for 5 cycles in CPU_ACC → mem_* stable throughout; stall lasts 7 cycles total.
- Reset mid-op: reset asserted during DMA_ACC → mem_req = 0 immediately; after release, state is IDLE and the CPU wins the first tie.
